key_debounce: RTL and testbench
===============================

# key_debounce

Per-key synchronizer and debouncer that sits directly upstream of the key PIO's input port. It cleans the raw push-button pins before the Avalon key PIO samples them, and adds one-cycle press/release pulses for fabric logic such as audio control FSMs. The debounced level output keeps the pin polarity, so the PIO and existing software see the same encoding, just without bounce.

## Interface
Parameters:
- NUM_KEYS, default 2: number of independent key channels.
- DEBOUNCE_CYCLES, default 500000 (10 ms at 50 MHz): consecutive stable cycles required to accept a change. Legal range is ≥1.
- ACTIVE_LOW, default 1: 1 means a pin level of 0 is "pressed". This sets the reset level and the pulse polarity.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- reset_n  in  1  reset, asynchronous, active-low.
- key_in  in  NUM_KEYS  raw asynchronous button pins.
- key_level  out  NUM_KEYS  debounced level, same polarity as key_in; drives the PIO in_port.
- key_press  out  NUM_KEYS  one-cycle high pulse when a key is accepted as pressed.
- key_release  out  NUM_KEYS  one-cycle high pulse when a key is accepted as released.

## Operation
Each key channel k is independent and identical.
- Synchronizer: two flops, sync1[k] <= key_in[k], then sync2[k] <= sync1[k]. Only sync2 is used downstream.
- State: stable[k] drives key_level[k]. cnt[k] is an unsigned counter of width max(1, clog2(DEBOUNCE_CYCLES)).
- Each clock edge:
  - If sync2[k] == stable[k]: cnt[k] <= 0.
  - Else if cnt[k] == DEBOUNCE_CYCLES-1: stable[k] <= sync2[k] and cnt[k] <= 0.
  - Else: cnt[k] <= cnt[k]+1.
- A single matching cycle during a mismatch run restarts the count from 0. The count never accumulates across separate runs.
- Pulses are registered on the same edge that updates stable[k]:
  - key_press[k] <= 1 when stable[k] moves to the pressed level (0 if ACTIVE_LOW, else 1).
  - key_release[k] <= 1 when stable[k] moves to the released level.
  - Both pulses are 0 on every other edge. key_press and key_release are never high together on the same key.
- Counter overflow is impossible: cnt is bounded at DEBOUNCE_CYCLES-1.
- With DEBOUNCE_CYCLES = 1, a change is accepted on the first mismatch cycle.

## Timing
- Reset (asynchronous assert; deassert synchronized externally):
  - sync1, sync2, stable and key_level = released level (all 1s if ACTIVE_LOW).
  - cnt = 0.
  - key_press = key_release = 0.
- Latency: let key_in change and be sampled at edge E0 and then stay constant.
  - sync2 shows the new value after E1.
  - stable and key_level update at E(1+DEBOUNCE_CYCLES).
  - The pulse is high for exactly the one cycle following that edge.
- Rejection: any mismatch run shorter than DEBOUNCE_CYCLES cycles (measured at sync2) produces no change and no pulse.
- Simultaneous events: keys changing on the same cycle are handled independently; their pulses may coincide.
- Reset mid-count: the count is discarded and all outputs return to reset values immediately. A key held pressed through reset is re-debounced from scratch after release of reset, and its press pulse is generated then.
- No combinational path from key_in to any output.

## Test plan
- Reset: NUM_KEYS=2, ACTIVE_LOW=1, DEBOUNCE_CYCLES=4, key_in=2'b11 held -> key_level=2'b11, press=release=0, all cnt=0.
- Clean press: key_in[0] 1→0 sampled at E0, then held -> key_level[0]=0 after E5, key_press[0]=1 for exactly the cycle after E5, key_level[1] unchanged at 1.
- Bounce rejection: key_in[0] toggles 0,1,0,1 with each level held 3 cycles, then returns to 1 -> key_level stays 2'b11, no pulses.
- Bounce then settle: 3-cycle bounces, then 0 held 10 cycles, then 1 held 10 cycles -> exactly one key_press[0] and one key_release[0] pulse. key_release[0] occurs 6 edges after the 0→1 input change.
- Simultaneous keys: key_in 2'b11→2'b00 on the same edge -> key_press=2'b11 on the same cycle. A later 2'b00→2'b10 gives only key_release[1].
- Reset mid-count: assert reset_n=0 for 1 cycle when cnt[0]=2 during a press -> outputs at reset values. After release with key_in[0]=0 held, key_press[0] fires 5 edges after the first post-reset edge.

Source files
------------

// File: rtl/key_debounce.sv
// Per-key two-flop synchronizer and counter debouncer feeding the key PIO.
// Level output keeps pin polarity; press/release are one-cycle strobes.
module key_debounce_lane #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int ACTIVE_LOW      = 1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic key_in,
  output logic key_level,
  output logic key_press,
  output logic key_release
);
  localparam int              CW      = ($clog2(DEBOUNCE_CYCLES) > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic            REL     = (ACTIVE_LOW != 0);
  localparam logic [CW-1:0]   CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1, sync2, stable;
  logic [CW-1:0] cnt;
  logic          accept;

  // A mismatch that has persisted DEBOUNCE_CYCLES edges is taken as the new level.
  assign accept = (sync2 != stable) && (cnt == CNT_MAX);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1       <= REL;
      sync2       <= REL;
      stable      <= REL;
      cnt         <= '0;
      key_press   <= 1'b0;
      key_release <= 1'b0;
    end else begin
      sync1       <= key_in;
      sync2       <= sync1;
      key_press   <= accept && (sync2 != REL);
      key_release <= accept && (sync2 == REL);
      if (sync2 == stable || accept) cnt <= '0;
      else                           cnt <= cnt + CW'(1);
      if (accept) stable <= sync2;
    end
  end

  assign key_level = stable;
endmodule

module key_debounce #(
  parameter int NUM_KEYS        = 2,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int ACTIVE_LOW      = 1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [NUM_KEYS-1:0] key_in,
  output logic [NUM_KEYS-1:0] key_level,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release
);
  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
    key_debounce_lane #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .ACTIVE_LOW     (ACTIVE_LOW)
    ) u_lane (
      .clk        (clk),
      .reset_n    (reset_n),
      .key_in     (key_in[k]),
      .key_level  (key_level[k]),
      .key_press  (key_press[k]),
      .key_release(key_release[k])
    );
  end
endmodule

// File: tb/tb_key_debounce.sv
// Scoreboarded bench: a sliding-window reference model predicts every cycle's
// outputs; a negedge monitor compares, plus directed latency/pulse-count checks.
module tb_key_debounce;
  localparam int   NK  = 2;
  localparam int   D   = 4;
  localparam logic REL = 1'b1;

  logic          clk = 1'b0, reset_n = 1'b0;
  logic [NK-1:0] key_in = '1;
  logic [NK-1:0] key_level, key_press, key_release;

  int errors = 0, checks = 0, cyc = 0;
  int pc [NK], rc [NK], pcyc [NK], rcyc [NK];

  typedef struct packed { logic [NK-1:0] lvl, prs, rls; } exp_t;
  exp_t q[$];

  key_debounce #(.NUM_KEYS(NK), .DEBOUNCE_CYCLES(D), .ACTIVE_LOW(1)) dut (
    .clk(clk), .reset_n(reset_n), .key_in(key_in),
    .key_level(key_level), .key_press(key_press), .key_release(key_release)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Reference: a level is accepted once the last D synchronized samples all
  // disagree with the current accepted level.
  logic [NK-1:0] m_s1 = '1, m_s2 = '1, m_lvl = '1;
  logic [D-1:0]  m_hist [NK];

  always @(posedge clk or negedge reset_n) begin
    exp_t e;
    if (!reset_n) begin
      m_s1 = {NK{REL}}; m_s2 = {NK{REL}}; m_lvl = {NK{REL}};
      for (int k = 0; k < NK; k++) m_hist[k] = {D{REL}};
      e.lvl = {NK{REL}}; e.prs = '0; e.rls = '0;
      q.delete();
      q.push_back(e);
    end else begin
      e.prs = '0; e.rls = '0;
      for (int k = 0; k < NK; k++) begin
        m_hist[k] = {m_hist[k][D-2:0], m_s2[k]};
        if (m_hist[k] == {D{~m_lvl[k]}}) begin
          m_lvl[k] = ~m_lvl[k];
          if (m_lvl[k] == REL) e.rls[k] = 1'b1;
          else                 e.prs[k] = 1'b1;
        end
      end
      m_s2 = m_s1;
      m_s1 = key_in;
      e.lvl = m_lvl;
      q.push_back(e);
    end
  end

  initial for (int k = 0; k < NK; k++) begin pc[k] = 0; rc[k] = 0; pcyc[k] = 0; rcyc[k] = 0; end

  always @(negedge clk) begin
    exp_t e;
    checks++;
    if (q.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty at cycle %0d", cyc);
    end else begin
      e = q.pop_front();
      if ({key_level, key_press, key_release} !== e) begin
        errors++;
        $display("FAIL outputs cycle %0d: got lvl=%b prs=%b rls=%b, want lvl=%b prs=%b rls=%b",
                 cyc, key_level, key_press, key_release, e.lvl, e.prs, e.rls);
      end
    end
    for (int k = 0; k < NK; k++) begin
      if (key_press[k] === 1'b1)   begin pc[k]++; pcyc[k] = cyc; end
      if (key_release[k] === 1'b1) begin rc[k]++; rcyc[k] = cyc; end
    end
  end

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  // Apply v just after an edge and hold it for n edges.
  task automatic hold(input logic [NK-1:0] v, input int n);
    key_in = v;
    repeat (n) begin @(posedge clk); #2; end
  endtask

  initial begin
    int p0, p1, r0, r1, t0;
    repeat (3) begin @(posedge clk); #2; end
    chk("reset_level", int'(key_level), 3);
    chk("reset_pulses", int'({key_press, key_release}), 0);
    reset_n = 1'b1;
    hold(2'b11, 4);

    // clean press on key 0, then release
    p0 = pc[0]; p1 = pc[1]; r0 = rc[0];
    t0 = cyc + 1; hold(2'b10, 8);
    chk("clean_press_count0", pc[0] - p0, 1);
    chk("clean_press_latency", pcyc[0] - t0, 5);
    chk("clean_press_key1_quiet", pc[1] - p1, 0);
    chk("clean_press_level", int'(key_level), 2);
    hold(2'b11, 8);
    chk("clean_release_count0", rc[0] - r0, 1);

    // bounce rejection: every run shorter than D
    p0 = pc[0]; r0 = rc[0];
    repeat (2) begin hold(2'b10, 3); hold(2'b11, 3); end
    hold(2'b11, 8);
    chk("bounce_no_press", pc[0] - p0, 0);
    chk("bounce_no_release", rc[0] - r0, 0);
    chk("bounce_level", int'(key_level), 3);

    // bounce then settle
    p0 = pc[0]; r0 = rc[0];
    hold(2'b10, 3); hold(2'b11, 3); hold(2'b10, 3); hold(2'b11, 3);
    hold(2'b10, 10);
    t0 = cyc + 1; hold(2'b11, 10);
    chk("settle_press_count", pc[0] - p0, 1);
    chk("settle_release_count", rc[0] - r0, 1);
    chk("settle_release_latency", rcyc[0] - t0, 5);

    // simultaneous keys
    p0 = pc[0]; p1 = pc[1]; r0 = rc[0]; r1 = rc[1];
    t0 = cyc + 1; hold(2'b00, 8);
    chk("simul_press0", pc[0] - p0, 1);
    chk("simul_press1", pc[1] - p1, 1);
    chk("simul_press1_latency", pcyc[1] - t0, 5);
    chk("simul_same_cycle", pcyc[0], pcyc[1]);
    hold(2'b10, 8);
    chk("simul_release1", rc[1] - r1, 1);
    chk("simul_no_release0", rc[0] - r0, 0);
    hold(2'b11, 8);

    // reset mid-count: press discarded, re-debounced after reset
    p0 = pc[0];
    hold(2'b10, 4);
    reset_n = 1'b0;
    hold(2'b10, 1);
    chk("midreset_level", int'(key_level), 3);
    reset_n = 1'b1;
    t0 = cyc + 1; hold(2'b10, 8);
    chk("midreset_press_count", pc[0] - p0, 1);
    chk("midreset_press_latency", pcyc[0] - t0, 5);
    hold(2'b11, 8);

    // random stimulus with occasional reset
    for (int i = 0; i < 250; i++) begin
      if ($urandom_range(0, 39) == 0) begin
        reset_n = 1'b0;
        hold(NK'($urandom), 1);
        reset_n = 1'b1;
      end
      hold(NK'($urandom), $urandom_range(1, 7));
    end
    hold(2'b11, 8);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
